// File: rtl/uart_rx_controlunit_pkg.sv
// uart_pkg: definitions shared by the UART receive and transmit control units.
//   - line_control_reg field positions and word-length codes
//   - receive FSM state encoding
//   - default oversampling ratio
package uart_pkg;

  localparam int LCR_WIDTH    = 5;
  localparam int LCR_WLEN_LSB = 0;
  localparam int LCR_WLEN_MSB = 1;
  localparam int LCR_STOP_BIT = 2;
  localparam int LCR_PEN_BIT  = 3;
  localparam int LCR_EPS_BIT  = 4;

  localparam logic [1:0] WLEN_5 = 2'b00;
  localparam logic [1:0] WLEN_6 = 2'b01;
  localparam logic [1:0] WLEN_7 = 2'b10;
  localparam logic [1:0] WLEN_8 = 2'b11;

  localparam int OVERSAMPLE_DEFAULT = 16;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  // Number of data bits encoded by the LCR word-length field.
  function automatic logic [3:0] word_len(input logic [1:0] wlen);
    logic [3:0] n;
    case (wlen)
      WLEN_5:  n = 4'd5;
      WLEN_6:  n = 4'd6;
      WLEN_7:  n = 4'd7;
      WLEN_8:  n = 4'd8;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/uart_rx_controlunit_if.sv
// Host-side bundle of the UART receiver.
//   line_control_reg : frame format (host -> receiver)
//   data_output      : received word, LSB aligned
//   data_valid       : one-cycle strobe qualifying data_output and the flags
//   parity_error, framing_error, break_detect : per-frame status
//   rx_busy          : a validated frame is in progress
// slave is the receiver's view, master the host's view.
interface uart_rx_controlunit_if;
  import uart_pkg::*;

  logic [LCR_WIDTH-1:0] line_control_reg;
  logic [7:0]           data_output;
  logic                 data_valid;
  logic                 parity_error;
  logic                 framing_error;
  logic                 break_detect;
  logic                 rx_busy;

  modport master (
    output line_control_reg,
    input  data_output, data_valid, parity_error, framing_error, break_detect, rx_busy
  );

  modport slave (
    input  line_control_reg,
    output data_output, data_valid, parity_error, framing_error, break_detect, rx_busy
  );

endinterface

// File: rtl/uart_rx_controlunit_sampler.sv
// uart_rx_sampler: front end of the UART receiver.
//   baud_clk  : oversampling clock
//   rst       : asynchronous active-low reset (all flops preset to line idle = 1)
//   rx_serial : asynchronous serial line
//   tick      : position inside the current bit period, from the control unit
//   sync_rx   : rx_serial after the 2-flop synchronizer
//   fall_edge : synced line went 1 -> 0 on this cycle
//   voted_bit : majority of the samples at ticks M-1, M and the current (M+1) value;
//               only meaningful on tick M+1
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic                          baud_clk,
  input  logic                          rst,
  input  logic                          rx_serial,
  input  logic [$clog2(OVERSAMPLE)-1:0] tick,
  output logic                          sync_rx,
  output logic                          fall_edge,
  output logic                          voted_bit
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int M  = OVERSAMPLE / 2;

  logic [1:0] sync_q;
  logic       prev_q;
  logic       samp_a_q;
  logic       samp_b_q;

  always_ff @(posedge baud_clk or negedge rst) begin
    if (!rst) begin
      sync_q   <= 2'b11;
      prev_q   <= 1'b1;
      samp_a_q <= 1'b1;
      samp_b_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], rx_serial};
      prev_q <= sync_q[1];
      if (tick == TW'(M - 1)) samp_a_q <= sync_q[1];
      if (tick == TW'(M))     samp_b_q <= sync_q[1];
    end
  end

  assign sync_rx   = sync_q[1];
  assign fall_edge = prev_q & ~sync_q[1];
  // Third vote is the live synced value, so the decision is available on tick M+1.
  assign voted_bit = (samp_a_q & samp_b_q) | (samp_a_q & sync_q[1]) | (samp_b_q & sync_q[1]);

endmodule

// File: rtl/uart_rx_controlunit.sv
// uart_rx_controlunit: receive control unit of the UART.
//   baud_clk  : OVERSAMPLE x baud rate clock
//   rst       : asynchronous active-low reset
//   rx_serial : serial line, idle high
//   host      : host bundle (line_control_reg in; data_output, data_valid,
//               parity_error, framing_error, break_detect, rx_busy out)
//
// state        | meaning
// -------------+------------------------------------------------------------
// RX_IDLE      | line idle, tick counter held at 0, waiting for falling edge
// RX_START     | confirm start bit at the vote tick; false start -> RX_IDLE
// RX_DATA      | shift in word-length data bits, LSB first
// RX_PARITY    | sample parity bit, record mismatch
// RX_STOP      | sample first stop bit, publish word and flags
// RX_WAIT_HIGH | break seen, hold busy until the line returns high
module uart_rx_controlunit
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic                  baud_clk,
  input  logic                  rst,
  input  logic                  rx_serial,
  uart_rx_controlunit_if.slave  host
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int M  = OVERSAMPLE / 2;
  localparam logic [TW-1:0] VOTE_TICK = TW'(M + 1);

  rx_state_t     state_q, state_d;
  logic [TW-1:0] tick_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic [1:0]    wlen_q;
  logic          pen_q;
  logic          eps_q;
  logic          par_bit_q;
  logic          par_err_q;

  logic [7:0]    data_q;
  logic          dv_q;
  logic          pe_q;
  logic          fe_q;
  logic          bd_q;

  logic          sync_rx;
  logic          fall_edge;
  logic          voted_bit;

  logic          vote_tick;
  logic          last_bit;
  logic          is_break;
  logic [7:0]    data_aligned;
  logic          start_ok;
  logic          shift_en;
  logic          par_en;
  logic          stop_en;

  // The stop-bit count only matters to the transmitter.
  logic          unused_stop_bit;
  assign unused_stop_bit = host.line_control_reg[LCR_STOP_BIT];

  uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
    .baud_clk  (baud_clk),
    .rst       (rst),
    .rx_serial (rx_serial),
    .tick      (tick_q),
    .sync_rx   (sync_rx),
    .fall_edge (fall_edge),
    .voted_bit (voted_bit)
  );

  assign vote_tick    = (tick_q == VOTE_TICK);
  assign last_bit     = ({1'b0, bit_q} == (word_len(wlen_q) - 4'd1));
  // Bits enter at the MSB, so a short word sits in the top bits until realigned.
  assign data_aligned = shift_q >> (4'd8 - word_len(wlen_q));
  assign is_break     = (data_aligned == 8'h00) && !(pen_q && par_bit_q) && !voted_bit;

  always_ff @(posedge baud_clk or negedge rst) begin
    if (!rst) state_q <= RX_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    shift_en = 1'b0;
    par_en   = 1'b0;
    stop_en  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (fall_edge) state_d = RX_START;
      end
      RX_START: begin
        if (vote_tick) begin
          if (voted_bit) begin
            state_d = RX_IDLE;
          end else begin
            state_d  = RX_DATA;
            start_ok = 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (vote_tick) begin
          shift_en = 1'b1;
          if (last_bit) state_d = pen_q ? RX_PARITY : RX_STOP;
        end
      end
      RX_PARITY: begin
        if (vote_tick) begin
          par_en  = 1'b1;
          state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        // Leaving mid stop bit re-arms the receiver for a back-to-back start.
        if (vote_tick) begin
          stop_en = 1'b1;
          state_d = is_break ? RX_WAIT_HIGH : RX_IDLE;
        end
      end
      RX_WAIT_HIGH: begin
        if (sync_rx) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge baud_clk or negedge rst) begin
    if (!rst) begin
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      wlen_q    <= '0;
      pen_q     <= 1'b0;
      eps_q     <= 1'b0;
      par_bit_q <= 1'b0;
      par_err_q <= 1'b0;
      data_q    <= '0;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      fe_q      <= 1'b0;
      bd_q      <= 1'b0;
    end else begin
      dv_q <= 1'b0;

      // Held at 0 while idle so the first START cycle is tick 0.
      if (state_q == RX_IDLE) tick_q <= '0;
      else                    tick_q <= tick_q + TW'(1);

      if (start_ok) begin
        wlen_q    <= host.line_control_reg[LCR_WLEN_MSB:LCR_WLEN_LSB];
        pen_q     <= host.line_control_reg[LCR_PEN_BIT];
        eps_q     <= host.line_control_reg[LCR_EPS_BIT];
        bit_q     <= '0;
        shift_q   <= '0;
        par_bit_q <= 1'b0;
        par_err_q <= 1'b0;
      end

      if (shift_en) begin
        shift_q <= {voted_bit, shift_q[7:1]};
        bit_q   <= bit_q + 3'd1;
      end

      if (par_en) begin
        par_bit_q <= voted_bit;
        par_err_q <= voted_bit != (eps_q ? ^data_aligned : ~^data_aligned);
      end

      if (stop_en) begin
        dv_q   <= 1'b1;
        data_q <= data_aligned;
        pe_q   <= par_err_q;
        fe_q   <= ~voted_bit;
        bd_q   <= is_break;
      end
    end
  end

  assign host.data_output   = data_q;
  assign host.data_valid    = dv_q;
  assign host.parity_error  = pe_q;
  assign host.framing_error = fe_q;
  assign host.break_detect  = bd_q;
  assign host.rx_busy       = (state_q == RX_DATA)   || (state_q == RX_PARITY) ||
                              (state_q == RX_STOP)   || (state_q == RX_WAIT_HIGH);

endmodule

// File: tb/tb_uart_rx_controlunit.sv
// Bench for uart_rx_controlunit: directed frames, a frame-level expectation
// queue built from the frame contents, and a per-cycle compare process.
module tb_uart_rx_controlunit;

  localparam int OS = 16;
  localparam int M  = OS / 2;

  logic baud_clk  = 1'b0;
  logic rst       = 1'b0;
  logic rx_serial = 1'b1;

  uart_rx_controlunit_if hif();

  uart_rx_controlunit #(.OVERSAMPLE(OS)) dut (
    .baud_clk  (baud_clk),
    .rst       (rst),
    .rx_serial (rx_serial),
    .host      (hif)
  );

  always #5 baud_clk = ~baud_clk;

  int cyc = 0;
  always @(posedge baud_clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [7:0] data;
    logic       pe;
    logic       fe;
    logic       bd;
  } exp_t;

  exp_t exp_q[$];
  exp_t cmp_e;

  int asserts     = 0;
  int failures    = 0;
  int dv_count    = 0;
  int last_dv_cyc = 0;
  int frame_k     = 0;
  logic [10:0] held = '0;
  logic prev_dv = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the expectation queue and the held values.
  always @(negedge baud_clk) begin
    if (!rst) begin
      check("reset_outputs",
            {hif.data_output, hif.data_valid, hif.parity_error, hif.framing_error,
             hif.break_detect, hif.rx_busy}, 32'h0);
      held = '0;
      exp_q.delete();
      prev_dv = 1'b0;
    end else begin
      check("dv_single_cycle", {31'h0, prev_dv & hif.data_valid}, 32'h0);
      if (hif.data_valid) begin
        dv_count++;
        last_dv_cyc = cyc;
        if (exp_q.size() == 0) begin
          asserts++;
          failures++;
          $display("FAIL unexpected_dv: data_valid with data 0x%0h at cycle %0d, none expected",
                   hif.data_output, cyc);
        end else begin
          cmp_e = exp_q.pop_front();
          check("dv_cycle", cyc, cmp_e.due);
          check("data_output", {24'h0, hif.data_output}, {24'h0, cmp_e.data});
          check("flags", {29'h0, hif.parity_error, hif.framing_error, hif.break_detect},
                {29'h0, cmp_e.pe, cmp_e.fe, cmp_e.bd});
          held = {cmp_e.data, cmp_e.pe, cmp_e.fe, cmp_e.bd};
        end
      end else begin
        check("hold_outputs",
              {21'h0, hif.data_output, hif.parity_error, hif.framing_error, hif.break_detect},
              {21'h0, held});
        if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
          asserts++;
          failures++;
          $display("FAIL missed_dv: no data_valid by cycle %0d, expected at cycle %0d",
                   cyc, exp_q[0].due);
          cmp_e = exp_q.pop_front();
        end
      end
      prev_dv = hif.data_valid;
    end
  end

  task automatic bit_period(input logic v);
    rx_serial = v;
    repeat (OS) @(posedge baud_clk);
    #1;
  endtask

  // Sends start + data (LSB first) + optional parity + one stop bit and queues
  // the outcome implied by the format in force at the start bit.
  task automatic send_frame(input logic [7:0] d, input logic [4:0] lcr,
                            input logic par_bit, input logic stop_bit,
                            input bit do_mid, input logic [4:0] lcr_mid);
    int n;
    logic pen, even, exp_par;
    logic [7:0] dm;
    exp_t e;
    n    = int'(lcr[1:0]) + 5;
    pen  = lcr[3];
    even = lcr[4];
    dm   = '0;
    for (int i = 0; i < n; i++) dm[i] = d[i];
    exp_par = even ? ^dm : ~^dm;
    hif.line_control_reg = lcr;
    frame_k = cyc;
    // rx changes just after edge k, so edge k+1 is the first to see it.
    e.due  = frame_k + 1 + 2 + (1 + n + int'(pen)) * OS + M + 2;
    e.data = dm;
    e.pe   = pen && (par_bit != exp_par);
    e.fe   = !stop_bit;
    e.bd   = (dm == 8'h00) && (!pen || !par_bit) && !stop_bit;
    exp_q.push_back(e);
    bit_period(1'b0);
    for (int i = 0; i < n; i++) begin
      if (do_mid && i == 2) hif.line_control_reg = lcr_mid;
      bit_period(d[i]);
      if (i == 0) check("busy_in_frame", {31'h0, hif.rx_busy}, 32'h1);
    end
    if (pen) bit_period(par_bit);
    bit_period(stop_bit);
    rx_serial = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int d0;
    exp_t e;
    hif.line_control_reg = 5'b00011;
    rx_serial = 1'b1;
    rst = 1'b0;

    // 1: reset and idle
    repeat (5) @(posedge baud_clk);
    #1;
    check("reset_data", {24'h0, hif.data_output}, 32'h0);
    check("reset_busy", {31'h0, hif.rx_busy}, 32'h0);
    rst = 1'b1;
    repeat (20 * OS) @(posedge baud_clk);
    #1;
    check("idle_no_dv", dv_count, 0);

    // 2: 8N1, single frame then back-to-back pair
    d0 = dv_count;
    send_frame(8'hA5, 5'b00011, 1'b0, 1'b1, 0, 5'b0);
    check("a5_one_pulse", dv_count - d0, 1);
    check("a5_data", {24'h0, hif.data_output}, 32'hA5);
    check("a5_flags", {29'h0, hif.parity_error, hif.framing_error, hif.break_detect}, 32'h0);
    check("a5_latency", last_dv_cyc - frame_k, 157);
    check("a5_busy_after", {31'h0, hif.rx_busy}, 32'h0);
    d0 = dv_count;
    send_frame(8'hA5, 5'b00011, 1'b0, 1'b1, 0, 5'b0);
    send_frame(8'h5A, 5'b00011, 1'b0, 1'b1, 0, 5'b0);
    check("b2b_two_pulses", dv_count - d0, 2);
    check("b2b_data", {24'h0, hif.data_output}, 32'h5A);

    // 3: parity
    send_frame(8'hAA, 5'b11011, 1'b0, 1'b1, 0, 5'b0);
    check("even_ok_pe", {31'h0, hif.parity_error}, 32'h0);
    check("8e1_latency", last_dv_cyc - frame_k, 173);
    send_frame(8'hAA, 5'b11011, 1'b1, 1'b1, 0, 5'b0);
    check("even_bad_pe", {31'h0, hif.parity_error}, 32'h1);
    check("even_bad_data", {24'h0, hif.data_output}, 32'hAA);
    send_frame(8'hAA, 5'b01011, 1'b1, 1'b1, 0, 5'b0);
    check("odd_ok_pe", {31'h0, hif.parity_error}, 32'h0);

    // 4: 5-bit word, LCR changed mid-frame, then 8-bit frame
    send_frame(8'h0E, 5'b00000, 1'b0, 1'b1, 1, 5'b00011);
    check("5n1_data", {24'h0, hif.data_output}, 32'h0E);
    send_frame(8'hC3, 5'b00011, 1'b0, 1'b1, 0, 5'b0);
    check("after_lcr_change", {24'h0, hif.data_output}, 32'hC3);

    // 5a: short low glitch is a false start
    d0 = dv_count;
    rx_serial = 1'b0;
    repeat (4) @(posedge baud_clk);
    #1;
    rx_serial = 1'b1;
    for (int i = 0; i < 3 * OS; i++) begin
      @(posedge baud_clk);
      #1;
      check("glitch_busy", {31'h0, hif.rx_busy}, 32'h0);
    end
    check("glitch_no_dv", dv_count - d0, 0);

    // 5b: stop bit low
    send_frame(8'h81, 5'b00011, 1'b0, 1'b0, 0, 5'b0);
    check("framing_fe", {31'h0, hif.framing_error}, 32'h1);
    check("framing_bd", {31'h0, hif.break_detect}, 32'h0);
    check("framing_data", {24'h0, hif.data_output}, 32'h81);
    repeat (2 * OS) @(posedge baud_clk);
    #1;

    // 5c: break, 12 bit times low
    d0 = dv_count;
    rx_serial = 1'b0;
    frame_k = cyc;
    e.due = frame_k + 1 + 2 + 9 * OS + M + 2;
    e.data = 8'h00;
    e.pe = 1'b0;
    e.fe = 1'b1;
    e.bd = 1'b1;
    exp_q.push_back(e);
    repeat (12 * OS) @(posedge baud_clk);
    #1;
    check("break_busy_held", {31'h0, hif.rx_busy}, 32'h1);
    check("break_flags", {29'h0, hif.parity_error, hif.framing_error, hif.break_detect}, 32'h3);
    rx_serial = 1'b1;
    repeat (5) @(posedge baud_clk);
    #1;
    check("break_busy_release", {31'h0, hif.rx_busy}, 32'h0);
    check("break_one_pulse", dv_count - d0, 1);

    // 6: reset in the 4th data bit of a frame
    send_frame(8'h96, 5'b00011, 1'b0, 1'b1, 0, 5'b0);
    check("pre_reset_data", {24'h0, hif.data_output}, 32'h96);
    d0 = dv_count;
    bit_period(1'b0);
    bit_period(1'b0);
    bit_period(1'b0);
    bit_period(1'b1);
    rx_serial = 1'b1;
    repeat (M) @(posedge baud_clk);
    check("pre_reset_busy", {31'h0, hif.rx_busy}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_data", {24'h0, hif.data_output}, 32'h0);
    check("async_reset_busy", {31'h0, hif.rx_busy}, 32'h0);
    repeat (3) @(posedge baud_clk);
    #1;
    rst = 1'b1;
    repeat (2 * OS) @(posedge baud_clk);
    #1;
    check("reset_no_dv", dv_count - d0, 0);
    send_frame(8'h3C, 5'b00011, 1'b0, 1'b1, 0, 5'b0);
    check("post_reset_data", {24'h0, hif.data_output}, 32'h3C);

    repeat (40) @(posedge baud_clk);
    #1;
    check("pending_expect", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
